// File: rtl/kbd_pkg.sv
// Shared keypad geometry, index types and the column drive helper.
package kbd_pkg;

    localparam int NUM_COL = 4;
    localparam int NUM_ROW = 4;
    localparam int NUM_KEY = NUM_COL * NUM_ROW;

    typedef logic [3:0] key_idx_t;
    typedef logic [1:0] col_idx_t;

    // Active-low one-cold drive pattern for the selected column.
    function automatic logic [NUM_COL-1:0] col_drive(input col_idx_t col);
        logic [NUM_COL-1:0] one_hot;
        one_hot = {{(NUM_COL-1){1'b0}}, 1'b1} << col;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-set-bit selector: picks the smallest pending key index.
module key_prio_enc
    import kbd_pkg::*;
(
    input  logic [NUM_KEY-1:0] req,
    output key_idx_t           idx,
    output logic               any
);

    // Walk from the top bit down so the lowest set bit is the last to win.
    always_comb begin
        idx = '0;
        for (int i = NUM_KEY - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = key_idx_t'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, sweep-level
// debounce and one-strobe-per-new-press event generation.
module keypad_scanner
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [3:0]  key_col,
    input  logic [3:0]  key_row,
    output logic [15:0] key_state,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  DEB_MAX  = 8'(DEBOUNCE_CNT);

    logic [NUM_ROW-1:0] sync1_reg;
    logic [NUM_ROW-1:0] sync2_reg;
    col_idx_t           col_reg;
    col_idx_t           col_next;
    logic [15:0]        div_reg;
    logic [15:0]        div_next;
    logic [NUM_KEY-1:0] snap_reg;
    logic [NUM_KEY-1:0] snap_full;
    logic [NUM_KEY-1:0] prev_snap_reg;
    logic [NUM_KEY-1:0] prev_snap_next;
    logic [7:0]         stable_reg;
    logic [7:0]         stable_next;
    logic [NUM_KEY-1:0] key_state_reg;
    logic [NUM_KEY-1:0] key_state_next;
    logic [NUM_KEY-1:0] pending_reg;
    logic [NUM_KEY-1:0] pending_next;
    logic [NUM_KEY-1:0] new_mask;
    logic [NUM_KEY-1:0] emit_bit;
    logic               key_valid_reg;
    logic               key_valid_next;
    key_idx_t           key_code_reg;
    key_idx_t           key_code_next;
    logic               col_last;
    logic               sweep_end;
    logic               load;
    key_idx_t           emit_idx;
    logic               emit_any;

    assign col_last  = (div_reg == DIV_LAST);
    assign sweep_end = col_last && (col_reg == col_idx_t'(NUM_COL - 1));

    // Snapshot with the current column's rows merged in on its last cycle;
    // at sweep end this is the completed snapshot for the whole matrix.
    generate
        for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_snap
            assign snap_full[gi*NUM_ROW +: NUM_ROW] =
                (col_last && (col_reg == col_idx_t'(gi))) ? ~sync2_reg
                                                          : snap_reg[gi*NUM_ROW +: NUM_ROW];
        end
    endgenerate

    key_prio_enc u_prio (
        .req (pending_reg),
        .idx (emit_idx),
        .any (emit_any)
    );

    // Next-state logic: column timing, debounce counter, state load, event queue.
    always_comb begin
        div_next       = col_last ? 16'd0 : div_reg + 16'd1;
        col_next       = col_last ? col_reg + 2'd1 : col_reg;
        prev_snap_next = prev_snap_reg;
        stable_next    = stable_reg;
        load           = 1'b0;
        if (sweep_end) begin
            prev_snap_next = snap_full;
            if (snap_full == prev_snap_reg) begin
                stable_next = (stable_reg == DEB_MAX) ? stable_reg : stable_reg + 8'd1;
            end else begin
                stable_next = 8'd0;
            end
            // Load only on the transition into the stable condition.
            load = (stable_next == DEB_MAX) && (stable_reg != DEB_MAX);
        end
        new_mask       = load ? (snap_full & ~key_state_reg) : '0;
        key_state_next = load ? snap_full : key_state_reg;
        emit_bit       = '0;
        if (emit_any) begin
            emit_bit[emit_idx] = 1'b1;
        end
        // Emitted bit retires and fresh presses join on the same edge.
        pending_next   = (pending_reg & ~emit_bit) | new_mask;
        key_valid_next = emit_any;
        key_code_next  = emit_any ? emit_idx : '0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_reg     <= 4'hF;
            sync2_reg     <= 4'hF;
            col_reg       <= '0;
            div_reg       <= '0;
            snap_reg      <= '0;
            prev_snap_reg <= '0;
            stable_reg    <= '0;
            key_state_reg <= '0;
            pending_reg   <= '0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= '0;
        end else begin
            sync1_reg     <= key_row;
            sync2_reg     <= sync1_reg;
            col_reg       <= col_next;
            div_reg       <= div_next;
            snap_reg      <= snap_full;
            prev_snap_reg <= prev_snap_next;
            stable_reg    <= stable_next;
            key_state_reg <= key_state_next;
            pending_reg   <= pending_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
        end
    end

    assign key_col   = col_drive(col_reg);
    assign key_state = key_state_reg;
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign key_down  = |key_state_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: scripted sweep table, reset during emission,
// and randomized key patterns checked against a sweep-level reference model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SWEEP    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [15:0] key_state;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] pressed = '0;

    int total = 0;
    int bad   = 0;

    // Reference model: sweep-level debounce plus a FIFO of expected strobes.
    logic [15:0] m_state;
    logic [15:0] m_prev;
    logic [15:0] m_cur;
    int          m_run;
    int          m_pos;
    int          m_q[$];
    int          obs_q[$];

    typedef struct {
        logic [15:0] pressed;
        logic [15:0] exp_state;
        int          n;
        logic [11:0] codes;
    } vec_t;

    vec_t tbl[64];
    int   n_rows = 0;

    logic [15:0] rnd_p;
    int          quiet_cnt;
    int          code_seen;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_state (key_state),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!key_col[c] && pressed[c*4+r]) key_row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = '0;
        m_prev  = '0;
        m_run   = 0;
        m_pos   = 0;
        m_q.delete();
    endtask

    // Called at a negedge; holds reset for the given number of edges.
    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_key_col", 32'(key_col), 32'h0000000E);
            check("rst_key_state", 32'(key_state), 32'h0);
            check("rst_valid_code", 32'({key_valid, key_code}), 32'h0);
            check("rst_key_down", 32'(key_down), 32'h0);
        end
        model_reset();
        resetn = 1'b1;
    endtask

    // One clock: advance the model across the edge, then compare all outputs.
    task automatic run_cycle();
        logic       exp_v;
        logic [3:0] exp_c;
        logic [3:0] one_hot;
        logic [3:0] exp_col;
        int         code;
        @(posedge clk);
        exp_v = 1'b0;
        exp_c = 4'h0;
        if (m_q.size() > 0) begin
            code  = m_q.pop_front();
            exp_v = 1'b1;
            exp_c = 4'(code);
        end
        m_pos++;
        if (m_pos == SWEEP) begin
            m_pos = 0;
            if (m_cur == m_prev) m_run++;
            else m_run = 0;
            m_prev = m_cur;
            if (m_run == DEB) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_cur[k] && !m_state[k]) m_q.push_back(k);
                end
                m_state = m_cur;
            end
        end
        @(negedge clk);
        one_hot = 4'b0001 << (m_pos / SCAN_DIV);
        exp_col = ~one_hot;
        check("key_col", 32'(key_col), 32'(exp_col));
        check("key_state", 32'(key_state), 32'(m_state));
        check("key_down", 32'(key_down), 32'(m_state != 16'h0));
        check("valid_code", 32'({key_valid, key_code}), 32'({exp_v, exp_c}));
        if (key_valid) obs_q.push_back(int'(key_code));
    endtask

    // One full sweep with a fixed pressed pattern applied from its first cycle.
    task automatic run_sweep(input logic [15:0] p);
        pressed = p;
        m_cur   = p;
        obs_q.delete();
        repeat (SWEEP) run_cycle();
    endtask

    task automatic add_rows(input int cnt, input logic [15:0] p, input logic [15:0] st,
                            input int n, input logic [11:0] codes);
        for (int i = 0; i < cnt; i++) begin
            tbl[n_rows] = '{p, st, n, codes};
            n_rows++;
        end
    endtask

    initial begin
        // Idle scanning, then key 6 held.
        add_rows(4, 16'h0000, 16'h0000, 0, 12'h000);
        add_rows(3, 16'h0040, 16'h0000, 0, 12'h000);
        add_rows(1, 16'h0040, 16'h0040, 0, 12'h000);
        add_rows(1, 16'h0040, 16'h0040, 1, 12'h006);
        add_rows(3, 16'h0000, 16'h0040, 0, 12'h000);
        add_rows(2, 16'h0000, 16'h0000, 0, 12'h000);
        // Key 6 bouncing for five sweeps, then stable.
        add_rows(1, 16'h0040, 16'h0000, 0, 12'h000);
        add_rows(1, 16'h0000, 16'h0000, 0, 12'h000);
        add_rows(1, 16'h0040, 16'h0000, 0, 12'h000);
        add_rows(1, 16'h0000, 16'h0000, 0, 12'h000);
        add_rows(3, 16'h0040, 16'h0000, 0, 12'h000);
        add_rows(1, 16'h0040, 16'h0040, 0, 12'h000);
        add_rows(1, 16'h0040, 16'h0040, 1, 12'h006);
        add_rows(3, 16'h0000, 16'h0040, 0, 12'h000);
        add_rows(1, 16'h0000, 16'h0000, 0, 12'h000);
        // Keys 3, 9, 15 in the same sweep.
        add_rows(3, 16'h8208, 16'h0000, 0, 12'h000);
        add_rows(1, 16'h8208, 16'h8208, 0, 12'h000);
        add_rows(1, 16'h8208, 16'h8208, 3, 12'hF93);
        add_rows(3, 16'h0000, 16'h8208, 0, 12'h000);
        add_rows(1, 16'h0000, 16'h0000, 0, 12'h000);
        // Key 0 held, key 5 added, then both released.
        add_rows(3, 16'h0001, 16'h0000, 0, 12'h000);
        add_rows(1, 16'h0001, 16'h0001, 0, 12'h000);
        add_rows(1, 16'h0001, 16'h0001, 1, 12'h000);
        add_rows(3, 16'h0021, 16'h0001, 0, 12'h000);
        add_rows(1, 16'h0021, 16'h0021, 0, 12'h000);
        add_rows(1, 16'h0021, 16'h0021, 1, 12'h005);
        add_rows(3, 16'h0000, 16'h0021, 0, 12'h000);
        add_rows(2, 16'h0000, 16'h0000, 0, 12'h000);

        model_reset();
        do_reset(3);

        for (int i = 0; i < n_rows; i++) begin
            run_sweep(tbl[i].pressed);
            check("tbl_state", 32'(key_state), 32'(tbl[i].exp_state));
            check("tbl_nstrobe", 32'(obs_q.size()), 32'(tbl[i].n));
            for (int j = 0; j < tbl[i].n && j < obs_q.size(); j++) begin
                check("tbl_code", 32'(obs_q[j]), 32'(tbl[i].codes[j*4 +: 4]));
            end
            $display("sweep %0d pressed=%h key_state=%h strobes=%0d", i, tbl[i].pressed,
                     key_state, obs_q.size());
        end

        // Reset asserted while the second of three strobes is showing.
        do_reset(2);
        repeat (4) run_sweep(16'h8208);
        check("pre_rst_state", 32'(key_state), 32'h00008208);
        obs_q.delete();
        run_cycle();
        run_cycle();
        check("pre_rst_nstrobe", 32'(obs_q.size()), 32'd2);
        code_seen = (obs_q.size() > 1) ? obs_q[1] : -1;
        check("pre_rst_code2", 32'(code_seen), 32'd9);
        do_reset(1);
        quiet_cnt = 0;
        for (int s = 0; s < 3; s++) begin
            run_sweep(16'h8208);
            quiet_cnt += obs_q.size();
        end
        check("post_rst_quiet", 32'(quiet_cnt), 32'd0);
        check("post_rst_state", 32'(key_state), 32'h0);
        run_sweep(16'h8208);
        check("redebounce_state", 32'(key_state), 32'h00008208);
        run_sweep(16'h8208);
        check("redebounce_nstrobe", 32'(obs_q.size()), 32'd3);
        $display("reset-during-emission: strobes after redebounce=%0d", obs_q.size());

        // Randomized patterns, each held a random number of sweeps.
        do_reset(2);
        rnd_p = '0;
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                rnd_p = 16'($urandom) & 16'($urandom) & 16'($urandom);
            end
            run_sweep(rnd_p);
            $display("rand sweep %0d pressed=%h key_state=%h strobes=%0d", s, rnd_p,
                     key_state, obs_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning clock cycles each column is driven; legal values are 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 3, meaning consecutive identical full sweeps required before the debounced state changes; legal values are 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port key_col, output, 4 bits: active-low column drive; exactly one bit is 0 at any time.
REQ-006 SHALL have port key_row, input, 4 bits: asynchronous, active-low row sense, pulled up externally.
REQ-007 SHALL have port key_state, output, 16 bits: debounced pressed bitmap; bit index = col*4+row, 1 = pressed.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle press-event strobe.
REQ-009 SHALL have port key_code, output, 4 bits: index of the pressed key; meaningful only while key_valid=1.
REQ-010 SHALL have port key_down, output, 1 bit: OR-reduction of key_state.

Function
REQ-011 SHALL pass key_row through a 2-flop synchronizer; all row samples use the synchronized value.
REQ-012 SHALL hold each column for exactly SCAN_DIV cycles, sequence col 0,1,2,3,0,... with key_col = ~(4'b0001 << col).
REQ-013 SHALL sample the synchronized rows on the last cycle of each column into snapshot bits [col*4 +: 4], inverted so that 1 = pressed.
REQ-014 SHALL treat the last cycle of column 3 as sweep end; one sweep = 4*SCAN_DIV cycles.
REQ-015 SHALL, at sweep end, compare the completed snapshot with the previous sweep's snapshot: if equal, increment the stable counter (saturating at DEBOUNCE_CNT); if different, clear it to 0.
REQ-016 SHALL, on the cycle the stable counter reaches DEBOUNCE_CNT, load key_state with the snapshot; key_state SHALL NOT change at any other time.
REQ-017 SHALL, on each key_state load, OR new = snapshot & ~old key_state into a 16-bit pending mask; releases SHALL NOT alter pending.
REQ-018 SHALL, every cycle pending is nonzero, assert key_valid with key_code = lowest set pending index, and clear that bit the same edge.
REQ-019 SHALL, on simultaneous emit and load, compute pending_next = (pending & ~emitted_bit) | new; no event is lost or duplicated.
REQ-020 SHALL emit N simultaneous new presses as N strobes in ascending key_code order on N consecutive cycles.
REQ-021 SHALL hold key_code at 0 whenever key_valid=0.
REQ-022 SHALL make key_valid registered; the first strobe occurs the cycle after the key_state load.
REQ-023 SHALL leave key_state unchanged when held keys stay pressed; only 0->1 transitions produce strobes.

Reset
REQ-024 SHALL, while resetn=0 at a clock edge, set: col=0, key_col=4'b1110, column cycle counter=0, synchronizer=4'hF, snapshot=0, previous snapshot=0, stable counter=0, key_state=0, pending=0, key_valid=0, key_code=0, key_down=0.
REQ-025 SHALL, on reset mid-sweep or mid-emission, discard all partial snapshots and pending events; scanning restarts at column 0 on the first cycle after release.

Structure
REQ-026 SHALL place NUM_COL=4, NUM_ROW=4, NUM_KEY=16 and typedef key_idx_t (4-bit) in a shared package kbd_pkg.
REQ-027 SHALL implement the lowest-set-bit selector of REQ-018 as sub-module key_prio_enc (16-bit in, 4-bit index plus valid out, combinational).

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, sweep = 16 cycles)
REQ-028 SHALL check: reset released, no keys -> key_col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; key_state=0.
REQ-029 SHALL check: key 6 (col 1, row 2) held from before sweep 1 -> key_state=16'h0040 at the end of sweep 4, with exactly one strobe, key_code=6, on the next cycle.
REQ-030 SHALL check: key 6 bouncing (toggling each sweep for 5 sweeps), then stable -> no update until 3 consecutive matching sweeps; exactly one strobe.
REQ-031 SHALL check: keys 3, 9 and 15 pressed in the same sweep -> strobes with key_code 3, 9, 15 on three consecutive cycles.
REQ-032 SHALL check: key 0 held and key 5 added later -> only key_code 5 is strobed; releasing both clears key_state to 0 with no strobe.
REQ-033 SHALL check: resetn=0 asserted during the second of three pending strobes -> all outputs are at reset values the next cycle; no further strobes occur until a fresh debounce completes.
